// File: rtl/vram_write_scheduler_pkg.sv
// Shared types and constants for the VideoMemory write-port scheduler:
// fill FSM state encoding, arbitration grant encoding and bus widths.
package vga_sched_pkg;

  localparam int ADDR_W  = 16;
  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_FILL = 1'b1
  } grant_e;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// Bundle of CPU pixel-write, fill-engine and RAM write-port signals.
// slave = the scheduler, master = the execute stage / RAM side.
interface vram_write_scheduler_if #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 3
);
  import vga_sched_pkg::*;

  // Handshake: iCpuWrite and iFillStart are single-cycle pulses with no
  // back-pressure (there is no ready); oWriteEnable alone qualifies
  // oWriteAddress/oDataIn in the cycle it is high.
  logic               iCpuWrite;
  logic [COORD_W-1:0] iCpuCol;
  logic [COORD_W-1:0] iCpuRow;
  logic [COLOR_W-1:0] iCpuColor;
  logic               iFillStart;
  logic [COORD_W-1:0] iFillCol0;
  logic [COORD_W-1:0] iFillRow0;
  logic [COORD_W-1:0] iFillCol1;
  logic [COORD_W-1:0] iFillRow1;
  logic [COLOR_W-1:0] iFillColor;

  logic                 oFillBusy;
  logic                 oFillDone;
  logic                 oCpuOverflow;
  logic                 oWriteEnable;
  logic [2*COORD_W-1:0] oWriteAddress;
  logic [COLOR_W-1:0]   oDataIn;
  fill_state_e          dbgState;

  modport slave (
    input  iCpuWrite, iCpuCol, iCpuRow, iCpuColor,
    input  iFillStart, iFillCol0, iFillRow0, iFillCol1, iFillRow1, iFillColor,
    output oFillBusy, oFillDone, oCpuOverflow,
    output oWriteEnable, oWriteAddress, oDataIn, dbgState
  );

  modport master (
    output iCpuWrite, iCpuCol, iCpuRow, iCpuColor,
    output iFillStart, iFillCol0, iFillRow0, iFillCol1, iFillRow1, iFillColor,
    input  oFillBusy, oFillDone, oCpuOverflow,
    input  oWriteEnable, oWriteAddress, oDataIn, dbgState
  );

endinterface

// File: rtl/vram_write_scheduler_fifo.sv
// Small synchronous FIFO holding CPU pixel writes that lost arbitration.
// A push while full is accepted only when a pop happens in the same cycle.
module pixel_write_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW:0]      count;
  logic             doPush;
  logic             doPop;

  assign oEmpty = (count == '0);
  assign oFull  = (count == FULL_CNT);
  assign oData  = mem[rdPtr];
  assign doPop  = iPop && !oEmpty;
  assign doPush = iPush && (!oFull || doPop);

  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr] <= iData;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates the VideoMemory write port between CPU pixel writes and a
// rectangle-fill engine. Optional macro VRAM_CLEAR_ON_RESET_EN clears the screen after reset.
module vram_write_scheduler #(
  parameter int COORD_W    = 8,
  parameter int COLOR_W    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   Clock,
  input logic                   Reset,
  vram_write_scheduler_if.slave bus
);
  import vga_sched_pkg::*;

  localparam int AW = 2 * COORD_W;
  localparam int EW = AW + COLOR_W;

  fill_state_e        rState, nextState;
  grant_e             rLastGrant;
  logic [COORD_W-1:0] rCol, rRow, rColMin, rColMax, rRowMax;
  logic [COLOR_W-1:0] rFillColor;
  logic               rOverflow, rWe;
  logic [AW-1:0]      rAddr;
  logic [COLOR_W-1:0] rData;

  logic [EW-1:0]      incoming, fifoHead, cpuCand;
  logic               fifoEmpty, fifoFull, fifoPush, fifoPop;
  logic               cpuPending, fillPending, grantCpu, grantFill;
  logic               fillLast, dropWrite, startReq;
  logic [COORD_W-1:0] startColMin, startColMax, startRowMin, startRowMax;
  logic [COLOR_W-1:0] startColor;

`ifdef VRAM_CLEAR_ON_RESET_EN
  logic rClearPending;

  always_ff @(posedge Clock) begin
    if (Reset)                rClearPending <= 1'b1;
    else if (rState == IDLE)  rClearPending <= 1'b0;
  end
`endif

  // Corner normalisation so swapped corners scan identically.
  always_comb begin
    startReq    = bus.iFillStart;
    startColMin = (bus.iFillCol0 < bus.iFillCol1) ? bus.iFillCol0 : bus.iFillCol1;
    startColMax = (bus.iFillCol0 < bus.iFillCol1) ? bus.iFillCol1 : bus.iFillCol0;
    startRowMin = (bus.iFillRow0 < bus.iFillRow1) ? bus.iFillRow0 : bus.iFillRow1;
    startRowMax = (bus.iFillRow0 < bus.iFillRow1) ? bus.iFillRow1 : bus.iFillRow0;
    startColor  = bus.iFillColor;
`ifdef VRAM_CLEAR_ON_RESET_EN
    if (rClearPending) begin
      startReq    = 1'b1;
      startColMin = '0;
      startColMax = '1;
      startRowMin = '0;
      startRowMax = '1;
      startColor  = '0;
    end
`endif
  end

  // Bypass: an empty FIFO lets the incoming write compete directly.
  always_comb begin
    incoming    = {bus.iCpuCol, bus.iCpuRow, bus.iCpuColor};
    cpuPending  = !fifoEmpty || bus.iCpuWrite;
    cpuCand     = fifoEmpty ? incoming : fifoHead;
    fillPending = (rState == FILL);
    grantCpu    = cpuPending && (!fillPending || rLastGrant == GNT_FILL);
    grantFill   = fillPending && !grantCpu;
    fifoPop     = grantCpu && !fifoEmpty;
    fifoPush    = bus.iCpuWrite && !(grantCpu && fifoEmpty);
    dropWrite   = fifoPush && fifoFull && !fifoPop;
    fillLast    = (rCol == rColMax) && (rRow == rRowMax);
  end

  pixel_write_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .iPush  (fifoPush),
    .iData  (incoming),
    .iPop   (fifoPop),
    .oData  (fifoHead),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty)
  );

  always_comb begin
    nextState = rState;
    case (rState)
      IDLE:    if (startReq) nextState = FILL;
      FILL:    if (grantFill && fillLast) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) rState <= IDLE;
    else       rState <= nextState;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rCol       <= '0;
      rRow       <= '0;
      rColMin    <= '0;
      rColMax    <= '0;
      rRowMax    <= '0;
      rFillColor <= '0;
      rLastGrant <= GNT_FILL;
      rOverflow  <= 1'b0;
      rWe        <= 1'b0;
      rAddr      <= '0;
      rData      <= '0;
    end else begin
      if (rState == IDLE && startReq) begin
        rCol       <= startColMin;
        rRow       <= startRowMin;
        rColMin    <= startColMin;
        rColMax    <= startColMax;
        rRowMax    <= startRowMax;
        rFillColor <= startColor;
      end else if (grantFill) begin
        // Equality test before increment keeps the last coordinate from wrapping.
        if (rCol == rColMax) begin
          if (rRow != rRowMax) begin
            rCol <= rColMin;
            rRow <= rRow + 1'b1;
          end
        end else begin
          rCol <= rCol + 1'b1;
        end
      end

      if (grantCpu)       rLastGrant <= GNT_CPU;
      else if (grantFill) rLastGrant <= GNT_FILL;
      if (dropWrite)      rOverflow  <= 1'b1;

      rWe <= grantCpu || grantFill;
      if (grantCpu) begin
        rAddr <= cpuCand[EW-1:COLOR_W];
        rData <= cpuCand[COLOR_W-1:0];
      end else if (grantFill) begin
        rAddr <= {rCol, rRow};
        rData <= rFillColor;
      end else begin
        rAddr <= '0;
        rData <= '0;
      end
    end
  end

  assign bus.oFillBusy     = (rState != IDLE);
  assign bus.oFillDone     = (rState == DONE);
  assign bus.oCpuOverflow  = rOverflow;
  assign bus.oWriteEnable  = rWe;
  assign bus.oWriteAddress = rAddr;
  assign bus.oDataIn       = rData;
  assign bus.dbgState      = rState;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: queue-based reference model checked every
// cycle, directed scenarios with hand-computed literals, then random traffic.
module tb_vram_write_scheduler;
  localparam int COORD_W    = 8;
  localparam int COLOR_W    = 3;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  vram_write_scheduler_if #(.COORD_W(COORD_W), .COLOR_W(COLOR_W)) bus();

  vram_write_scheduler #(
    .COORD_W    (COORD_W),
    .COLOR_W    (COLOR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [18:0] cpu_q[$];
  logic [15:0] fill_q[$];
  logic [2:0]  m_fill_color;
  int          m_mode;      // 0 idle, 1 filling, 2 done
  int          m_next;
  bit          m_last_cpu;
  bit          m_consumed;
  logic [18:0] m_inc, m_w;
  int          cmin, cmax, rmin, rmax;
  logic        exp_we, exp_done, exp_busy, exp_ovf;
  logic [15:0] exp_addr;
  logic [2:0]  exp_data;
  bit          cmp_en = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      cpu_q.delete();
      fill_q.delete();
      m_mode = 0; m_last_cpu = 1'b0;
      exp_we = 0; exp_done = 0; exp_busy = 0; exp_ovf = 0;
      exp_addr = '0; exp_data = '0;
      cmp_en = 1'b1;
    end else begin
      m_inc = {bus.iCpuCol, bus.iCpuRow, bus.iCpuColor};
      m_consumed = 1'b0;
      m_next = m_mode;
      exp_we = 0; exp_addr = '0; exp_data = '0;
      if ((cpu_q.size() != 0 || bus.iCpuWrite) && (m_mode != 1 || !m_last_cpu)) begin
        if (cpu_q.size() != 0) m_w = cpu_q.pop_front();
        else begin m_w = m_inc; m_consumed = 1'b1; end
        exp_we = 1; exp_addr = m_w[18:3]; exp_data = m_w[2:0];
        m_last_cpu = 1'b1;
      end else if (m_mode == 1) begin
        exp_we = 1; exp_addr = fill_q.pop_front(); exp_data = m_fill_color;
        m_last_cpu = 1'b0;
        if (fill_q.size() == 0) m_next = 2;
      end
      if (bus.iCpuWrite && !m_consumed) begin
        if (cpu_q.size() < FIFO_DEPTH) cpu_q.push_back(m_inc);
        else exp_ovf = 1'b1;
      end
      if (m_mode == 0 && bus.iFillStart) begin
        cmin = (bus.iFillCol0 < bus.iFillCol1) ? int'(bus.iFillCol0) : int'(bus.iFillCol1);
        cmax = (bus.iFillCol0 < bus.iFillCol1) ? int'(bus.iFillCol1) : int'(bus.iFillCol0);
        rmin = (bus.iFillRow0 < bus.iFillRow1) ? int'(bus.iFillRow0) : int'(bus.iFillRow1);
        rmax = (bus.iFillRow0 < bus.iFillRow1) ? int'(bus.iFillRow1) : int'(bus.iFillRow0);
        for (int r = rmin; r <= rmax; r++)
          for (int c = cmin; c <= cmax; c++)
            fill_q.push_back({c[7:0], r[7:0]});
        m_fill_color = bus.iFillColor;
        m_next = 1;
      end
      if (m_mode == 2) m_next = 0;
      m_mode   = m_next;
      exp_done = (m_mode == 2);
      exp_busy = (m_mode != 0);
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [18:0] wr_log[$];
  logic [15:0] done_addr;
  int          done_cnt = 0;

  always @(negedge Clock) begin
    if (cmp_en) begin
      check("we", bus.oWriteEnable, exp_we);
      if (exp_we) begin
        check("addr", bus.oWriteAddress, exp_addr);
        check("data", bus.oDataIn, exp_data);
      end
      check("done", bus.oFillDone, exp_done);
      check("busy", bus.oFillBusy, exp_busy);
      check("ovf", bus.oCpuOverflow, exp_ovf);
      if (bus.oWriteEnable) wr_log.push_back({bus.oWriteAddress, bus.oDataIn});
      if (bus.oFillDone) begin done_cnt++; done_addr = bus.oWriteAddress; end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic cpu_write(input logic [7:0] c, input logic [7:0] r, input logic [2:0] col);
    bus.iCpuWrite = 1'b1; bus.iCpuCol = c; bus.iCpuRow = r; bus.iCpuColor = col;
    @(negedge Clock);
    bus.iCpuWrite = 1'b0;
  endtask

  task automatic start_fill(input logic [7:0] c0, input logic [7:0] r0,
                            input logic [7:0] c1, input logic [7:0] r1, input logic [2:0] col);
    bus.iFillStart = 1'b1;
    bus.iFillCol0 = c0; bus.iFillRow0 = r0; bus.iFillCol1 = c1; bus.iFillRow1 = r1;
    bus.iFillColor = col;
    @(negedge Clock);
    bus.iFillStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.oFillBusy !== 1'b0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_timeout_busy"}, bus.oFillBusy, 0);
    repeat (8) @(negedge Clock);
  endtask

  task automatic check_small_fill(input string tag);
    logic [15:0] exp_a[6];
    exp_a = '{16'h0203, 16'h0303, 16'h0403, 16'h0204, 16'h0304, 16'h0404};
    check({tag, "_count"}, wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_log[i][18:3], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), wr_log[i][2:0], 6);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_addr"}, done_addr, 16'h0404);
  endtask

  // ---------------- stimulus ----------------
  int          cpu_seen;
  logic [7:0]  exp_cols[10];
  logic [7:0]  base;

  initial begin
    bus.iCpuWrite = 0; bus.iCpuCol = 0; bus.iCpuRow = 0; bus.iCpuColor = 0;
    bus.iFillStart = 0; bus.iFillCol0 = 0; bus.iFillRow0 = 0;
    bus.iFillCol1 = 0; bus.iFillRow1 = 0; bus.iFillColor = 0;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_we", bus.oWriteEnable, 0);
    check("rst_addr", bus.oWriteAddress, 0);
    check("rst_busy", bus.oFillBusy, 0);
    check("rst_done", bus.oFillDone, 0);
    check("rst_ovf", bus.oCpuOverflow, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // Idle CPU write: visible one cycle later, gone the next.
    cpu_write(8'h10, 8'h20, 3'd5);
    check("t1_we", bus.oWriteEnable, 1);
    check("t1_addr", bus.oWriteAddress, 16'h1020);
    check("t1_data", bus.oDataIn, 5);
    @(negedge Clock);
    check("t1_we_off", bus.oWriteEnable, 0);
    repeat (2) @(negedge Clock);

    // Small fill, then the same rectangle with swapped corners.
    wr_log.delete(); done_cnt = 0;
    start_fill(8'd2, 8'd3, 8'd4, 8'd4, 3'd6);
    wait_idle("t2", 100);
    check_small_fill("t2");

    wr_log.delete(); done_cnt = 0;
    start_fill(8'd4, 8'd4, 8'd2, 8'd3, 3'd6);
    wait_idle("t3", 100);
    check_small_fill("t3");

    // Full-width row with one CPU write two cycles after start.
    wr_log.delete(); done_cnt = 0;
    start_fill(8'd0, 8'd0, 8'd255, 8'd0, 3'd2);
    @(negedge Clock);
    cpu_write(8'h80, 8'h80, 3'd1);
    wait_idle("t4", 400);
    check("t4_count", wr_log.size(), 257);
    if (wr_log.size() == 257) begin
      check("t4_cpu_slot", wr_log[1], {16'h8080, 3'd1});
      check("t4_last", wr_log[256], {16'hFF00, 3'd2});
    end
    check("t4_done_addr", done_addr, 16'hFF00);

    // CPU burst against an active fill: FIFO overflows, order kept.
    wr_log.delete(); done_cnt = 0;
    start_fill(8'd0, 8'd0, 8'd255, 8'd0, 3'd3);
    for (int i = 0; i < 12; i++) begin
      bus.iCpuWrite = 1'b1; bus.iCpuCol = 8'(i); bus.iCpuRow = 8'h40; bus.iCpuColor = 3'd5;
      @(negedge Clock);
    end
    bus.iCpuWrite = 1'b0;
    check("t5_ovf_set", bus.oCpuOverflow, 1);
    wait_idle("t5", 600);
    check("t5_ovf_sticky", bus.oCpuOverflow, 1);
    exp_cols = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10};
    cpu_seen = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i][2:0] == 3'd5) begin
        if (cpu_seen < 10) check($sformatf("t5_cpu_col%0d", cpu_seen), wr_log[i][18:11], exp_cols[cpu_seen]);
        cpu_seen++;
      end
    end
    check("t5_cpu_count", cpu_seen, 10);

    // Reset mid-fill with CPU writes queued.
    done_cnt = 0;
    start_fill(8'd0, 8'd0, 8'd255, 8'd0, 3'd4);
    for (int i = 0; i < 6; i++) begin
      bus.iCpuWrite = 1'b1; bus.iCpuCol = 8'(i + 8'h20); bus.iCpuRow = 8'h01; bus.iCpuColor = 3'd7;
      @(negedge Clock);
    end
    bus.iCpuWrite = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("t6_we", bus.oWriteEnable, 0);
    check("t6_busy", bus.oFillBusy, 0);
    check("t6_done", bus.oFillDone, 0);
    check("t6_ovf", bus.oCpuOverflow, 0);
    repeat (4) @(negedge Clock);
    check("t6_no_done_pulse", done_cnt, 0);
    wr_log.delete(); done_cnt = 0;
    start_fill(8'd2, 8'd3, 8'd4, 8'd4, 3'd6);
    wait_idle("t6b", 100);
    check_small_fill("t6b");

    // Random traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.iCpuWrite  = ($urandom_range(0, 2) == 0);
      bus.iCpuCol    = 8'($urandom_range(0, 255));
      bus.iCpuRow    = 8'($urandom_range(0, 255));
      bus.iCpuColor  = 3'($urandom_range(0, 7));
      bus.iFillStart = ($urandom_range(0, 40) == 0);
      base = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd250;
      bus.iFillCol0  = base + 8'($urandom_range(0, 5));
      bus.iFillCol1  = base + 8'($urandom_range(0, 5));
      bus.iFillRow0  = base + 8'($urandom_range(0, 5));
      bus.iFillRow1  = base + 8'($urandom_range(0, 5));
      bus.iFillColor = 3'($urandom_range(0, 7));
      Reset = ($urandom_range(0, 700) == 0);
      @(negedge Clock);
    end
    bus.iCpuWrite = 1'b0; bus.iFillStart = 1'b0; Reset = 1'b0;
    wait_idle("rand", 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
